// File: rtl/e203_irq_stim_gen.sv
// ---------------------------------------------------------------------------
// e203_irq_stim_gen
//
// Interrupt-stimulus generator for one IRQ line of e203_subsys_main. It
// watches the commit stage. When the commit of ARM_PC shows that mtvec has
// been set up, the block waits a pseudo-random number of cycles and then
// raises irq_o. It lowers irq_o again when the handler's pre-mret
// instruction (ACK_PC) commits. It then re-arms with a fresh random delay
// until MAX_IRQS interrupts have been acknowledged, stop_req is seen, or an
// acknowledge fails to arrive within ACK_TIMEOUT cycles.
//
// Ports
//   clk        in   1        core clock
//   rst_n      in   1        asynchronous active-low reset
//   enable     in   1        generator enable; low forces IDLE
//   cmt_valid  in   1        commit valid
//   cmt_pc     in   PC_SIZE  committing PC
//   stop_req   in   1        level: finish the current IRQ, then stop
//   irq_o      out  1        IRQ to the core (registered)
//   state_o    out  3        FSM state (IDLE=0 ARMED=1 DELAY=2 ASSERT=3 DONE=4)
//   irq_cnt_o  out  32       acknowledged IRQ count (saturating)
//   timeout_o  out  1        sticky acknowledge-timeout flag
// ---------------------------------------------------------------------------
module e203_irq_stim_gen #(
    parameter int unsigned          PC_SIZE     = 32,
    parameter logic [PC_SIZE-1:0]   ARM_PC      = PC_SIZE'(32'h8000015C),
    parameter logic [PC_SIZE-1:0]   ACK_PC      = PC_SIZE'(32'h800000A6),
    parameter int unsigned          DELAY_W     = 10,
    parameter logic [31:0]          LFSR_SEED   = 32'hACE12345,
    parameter int unsigned          MAX_IRQS    = 32,
    parameter int unsigned          ACK_TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               cmt_valid,
    input  logic [PC_SIZE-1:0] cmt_pc,
    input  logic               stop_req,
    output logic               irq_o,
    output logic [2:0]         state_o,
    output logic [31:0]        irq_cnt_o,
    output logic               timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_DELAY  = 3'd2,
        S_ASSERT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [31:0]          LFSR_TAPS = 32'h80200003;
    localparam int unsigned          WDOG_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WDOG_W-1:0]    WDOG_LAST = WDOG_W'(ACK_TIMEOUT - 1);
    localparam logic [WDOG_W-1:0]    WDOG_ONE  = {{(WDOG_W-1){1'b0}}, 1'b1};
    localparam logic [DELAY_W:0]     DLY_ONE   = {{DELAY_W{1'b0}}, 1'b1};
    localparam logic [31:0]          MAX_CNT   = MAX_IRQS;

    state_t              state;
    logic [31:0]         lfsr;
    logic [DELAY_W:0]    delay_cnt;
    logic [WDOG_W-1:0]   wdog;

    logic                hit_arm;
    logic                hit_ack;
    logic [31:0]         lfsr_next;
    logic [DELAY_W:0]    delay_seed;
    logic [31:0]         cnt_inc;

    assign hit_arm = cmt_valid && (cmt_pc == ARM_PC);
    assign hit_ack = cmt_valid && (cmt_pc == ACK_PC);

    // Galois form: shift right and fold the taps back in when a one drops out.
    assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);

    // One extra bit so that lfsr+1 can reach 2^DELAY_W without wrapping.
    assign delay_seed = {1'b0, lfsr[DELAY_W-1:0]} + DLY_ONE;

    // The count sticks at all-ones instead of wrapping back to zero.
    assign cnt_inc = (irq_cnt_o == 32'hFFFF_FFFF) ? irq_cnt_o : irq_cnt_o + 32'd1;

    assign state_o = state;

    // Whole generator FSM with its counters and registered outputs.
    // DELAY counts the loaded value d down to zero and raises the IRQ on the
    // edge that sees zero. If the arming (or acknowledging) commit is sampled
    // at edge T, irq_o is therefore high from edge T+1+d.
    // Dropping enable parks the block in IDLE but keeps the count and the
    // timeout flag, so software can still read what happened.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            irq_o     <= 1'b0;
            irq_cnt_o <= 32'd0;
            timeout_o <= 1'b0;
            lfsr      <= LFSR_SEED;
            delay_cnt <= '0;
            wdog      <= '0;
        end else begin
            if (enable) begin
                lfsr <= lfsr_next;
            end

            if (!enable) begin
                state     <= S_IDLE;
                irq_o     <= 1'b0;
                delay_cnt <= '0;
                wdog      <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_ARMED;
                    end

                    S_ARMED: begin
                        if (hit_arm) begin
                            state     <= S_DELAY;
                            delay_cnt <= delay_seed;
                        end
                    end

                    S_DELAY: begin
                        if (stop_req) begin
                            state     <= S_DONE;
                            delay_cnt <= '0;
                        end else if (delay_cnt == '0) begin
                            state <= S_ASSERT;
                            irq_o <= 1'b1;
                            wdog  <= '0;
                        end else begin
                            delay_cnt <= delay_cnt - DLY_ONE;
                        end
                    end

                    S_ASSERT: begin
                        // stop_req alone never drops the line. Only an ack
                        // or the watchdog ends the pulse.
                        if (hit_ack) begin
                            irq_o     <= 1'b0;
                            irq_cnt_o <= cnt_inc;
                            wdog      <= '0;
                            if (stop_req || (cnt_inc == MAX_CNT)) begin
                                state <= S_DONE;
                            end else begin
                                state     <= S_DELAY;
                                delay_cnt <= delay_seed;
                            end
                        end else if (wdog == WDOG_LAST) begin
                            irq_o     <= 1'b0;
                            timeout_o <= 1'b1;
                            wdog      <= '0;
                            state     <= S_DONE;
                        end else begin
                            wdog <= wdog + WDOG_ONE;
                        end
                    end

                    S_DONE: begin
                        irq_o <= 1'b0;
                    end

                    default: begin
                        state <= S_IDLE;
                        irq_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
